// File: rtl/pll_sup_pkg.sv
// ----------------------------------------------------------------------------
// pll_sup_pkg
//
// Shared definitions for the PLL lock supervisor:
//   - pll_state_e   : FSM state encodings (3-bit; codes 5..7 unused/illegal)
//   - StatusCntWidth: width of the saturating status counters
//   - sat_inc()     : saturating increment for the status counters
//   - max_u()       : helper used to size the shared down-counter
// ----------------------------------------------------------------------------
package pll_sup_pkg;

    typedef enum logic [2:0] {
        ST_PLL_RESET = 3'd0,
        ST_WAIT_LOCK = 3'd1,
        ST_STABILIZE = 3'd2,
        ST_HOLD      = 3'd3,
        ST_RUN       = 3'd4
    } pll_state_e;

    localparam int unsigned StatusCntWidth = 8;

    // Holds at all-ones instead of wrapping.
    function automatic logic [StatusCntWidth-1:0] sat_inc(
        input logic [StatusCntWidth-1:0] v
    );
        return (&v) ? v : v + 1'b1;
    endfunction

    function automatic int unsigned max_u(input int unsigned a, input int unsigned b);
        return (a > b) ? a : b;
    endfunction

endpackage

// File: rtl/sync_bit.sv
// ----------------------------------------------------------------------------
// sync_bit
//
// N-stage flip-flop synchronizer for a single asynchronous bit.
//
// Parameters:
//   Stages : number of flops in the chain (>= 2)
// Ports:
//   clk_i  : destination clock
//   rst_ni : asynchronous active-low reset, clears every stage to 0
//   d_i    : asynchronous input bit
//   q_o    : synchronized output (last stage)
// ----------------------------------------------------------------------------
module sync_bit #(
    parameter int unsigned Stages = 2
) (
    input  logic clk_i,
    input  logic rst_ni,
    input  logic d_i,
    output logic q_o
);

    logic [Stages-1:0] sync_q;

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            sync_q <= '0;
        end else begin
            sync_q <= {sync_q[Stages-2:0], d_i};
        end
    end

    assign q_o = sync_q[Stages-1];

endmodule

// File: rtl/pll_lock_supervisor.sv
// ----------------------------------------------------------------------------
// pll_lock_supervisor
//
// Consumes the PLL lock flag and drives the PLL reset. Synchronizes the lock
// flag, re-pulses the PLL reset when lock does not arrive within a timeout,
// holds the design reset until lock has been stable, and re-asserts the
// design reset on loss of lock while running.
//
// Parameters:
//   SYNC_STAGES         : synchronizer depth on pll_locked (>= 2)
//   LOCK_STABLE_CYCLES  : consecutive lock cycles needed in STABILIZE (>= 1)
//   RESET_HOLD_CYCLES   : extra cycles sys_reset stays high in HOLD (>= 1)
//   LOCK_TIMEOUT_CYCLES : WAIT_LOCK cycles before the PLL is reset again (>= 1)
//   PLL_RST_CYCLES      : width of the pll_rst pulse (>= 1)
// Ports:
//   clock           : free-running reference clock
//   reset_n         : asynchronous active-low reset
//   pll_locked      : PLL lock flag, asynchronous to clock
//   pll_rst         : PLL reset request, active high
//   sys_reset       : design reset, active high (low only in RUN)
//   ready           : high only in RUN
//   state           : current FSM state encoding
//   lost_lock_count : lock drops seen in RUN, saturating at 255
//   timeout_count   : WAIT_LOCK timeouts, saturating at 255
// ----------------------------------------------------------------------------
module pll_lock_supervisor
    import pll_sup_pkg::*;
#(
    parameter int unsigned SYNC_STAGES         = 2,
    parameter int unsigned LOCK_STABLE_CYCLES  = 1024,
    parameter int unsigned RESET_HOLD_CYCLES   = 16,
    parameter int unsigned LOCK_TIMEOUT_CYCLES = 1048576,
    parameter int unsigned PLL_RST_CYCLES      = 8
) (
    input  logic                      clock,
    input  logic                      reset_n,
    input  logic                      pll_locked,
    output logic                      pll_rst,
    output logic                      sys_reset,
    output logic                      ready,
    output logic [2:0]                state,
    output logic [StatusCntWidth-1:0] lost_lock_count,
    output logic [StatusCntWidth-1:0] timeout_count
);

    // One down-counter shared by all timed states, wide enough for the
    // largest reload value (largest parameter minus one).
    localparam int unsigned CntMax   = max_u(max_u(LOCK_STABLE_CYCLES, RESET_HOLD_CYCLES),
                                             max_u(LOCK_TIMEOUT_CYCLES, PLL_RST_CYCLES));
    localparam int unsigned CntWidth = (CntMax > 1) ? $clog2(CntMax) : 1;

    localparam logic [CntWidth-1:0] RstLoad     = CntWidth'(PLL_RST_CYCLES - 1);
    localparam logic [CntWidth-1:0] TimeoutLoad = CntWidth'(LOCK_TIMEOUT_CYCLES - 1);
    localparam logic [CntWidth-1:0] StableLoad  = CntWidth'(LOCK_STABLE_CYCLES - 1);
    localparam logic [CntWidth-1:0] HoldLoad    = CntWidth'(RESET_HOLD_CYCLES - 1);

    logic                      lock_s;
    pll_state_e                state_q, state_d;
    logic [CntWidth-1:0]       cnt_q, cnt_d, cnt_load;
    logic [StatusCntWidth-1:0] lost_q, lost_d;
    logic [StatusCntWidth-1:0] timeout_q, timeout_d;
    logic                      lost_inc, timeout_inc;
    logic                      pll_rst_q, pll_rst_d;
    logic                      sys_reset_q, sys_reset_d;
    logic                      ready_q, ready_d;

    // ------------------------------------------------------------------
    // Lock synchronizer
    // ------------------------------------------------------------------
    sync_bit #(
        .Stages (SYNC_STAGES)
    ) u_lock_sync (
        .clk_i  (clock),
        .rst_ni (reset_n),
        .d_i    (pll_locked),
        .q_o    (lock_s)
    );

    // ------------------------------------------------------------------
    // State register, shared counter, status counters, registered outputs
    // ------------------------------------------------------------------
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            state_q     <= ST_PLL_RESET;
            cnt_q       <= RstLoad;
            lost_q      <= '0;
            timeout_q   <= '0;
            pll_rst_q   <= 1'b1;
            sys_reset_q <= 1'b1;
            ready_q     <= 1'b0;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            lost_q      <= lost_d;
            timeout_q   <= timeout_d;
            pll_rst_q   <= pll_rst_d;
            sys_reset_q <= sys_reset_d;
            ready_q     <= ready_d;
        end
    end

    // ------------------------------------------------------------------
    // Next-state logic
    // ------------------------------------------------------------------
    always_comb begin
        state_d     = state_q;
        lost_inc    = 1'b0;
        timeout_inc = 1'b0;
        case (state_q)
            ST_PLL_RESET: begin
                if (cnt_q == '0) state_d = ST_WAIT_LOCK;
            end
            ST_WAIT_LOCK: begin
                // Lock takes priority over an expiring timeout.
                if (lock_s) begin
                    state_d = ST_STABILIZE;
                end else if (cnt_q == '0) begin
                    state_d     = ST_PLL_RESET;
                    timeout_inc = 1'b1;
                end
            end
            ST_STABILIZE: begin
                if (!lock_s)          state_d = ST_WAIT_LOCK;
                else if (cnt_q == '0) state_d = ST_HOLD;
            end
            ST_HOLD: begin
                if (!lock_s)          state_d = ST_WAIT_LOCK;
                else if (cnt_q == '0) state_d = ST_RUN;
            end
            ST_RUN: begin
                if (!lock_s) begin
                    state_d  = ST_WAIT_LOCK;
                    lost_inc = 1'b1;
                end
            end
            default: state_d = ST_PLL_RESET;
        endcase
    end

    // Reload value for the state being entered.
    always_comb begin
        cnt_load = '0;
        case (state_d)
            ST_PLL_RESET: cnt_load = RstLoad;
            ST_WAIT_LOCK: cnt_load = TimeoutLoad;
            ST_STABILIZE: cnt_load = StableLoad;
            ST_HOLD:      cnt_load = HoldLoad;
            default:      cnt_load = '0;
        endcase
    end

    // No state ever transitions to itself, so any change of state is an
    // entry and reloads the counter; otherwise count down and stop at zero.
    always_comb begin
        cnt_d = cnt_q;
        if (state_d != state_q) begin
            cnt_d = cnt_load;
        end else if (cnt_q != '0) begin
            cnt_d = cnt_q - 1'b1;
        end
    end

    always_comb begin
        lost_d    = lost_inc    ? sat_inc(lost_q)    : lost_q;
        timeout_d = timeout_inc ? sat_inc(timeout_q) : timeout_q;
    end

    // ------------------------------------------------------------------
    // Output decode from the next state, so outputs move with state
    // ------------------------------------------------------------------
    always_comb begin
        pll_rst_d   = (state_d == ST_PLL_RESET);
        ready_d     = (state_d == ST_RUN);
        sys_reset_d = (state_d != ST_RUN);
    end

    assign pll_rst         = pll_rst_q;
    assign sys_reset       = sys_reset_q;
    assign ready           = ready_q;
    assign state           = state_q;
    assign lost_lock_count = lost_q;
    assign timeout_count   = timeout_q;

endmodule
